// File: rtl/stream_shell_sync.sv
// stream_shell_sync: single-clock valid/ready stream buffer with a 2**NUM_ADDR_BITS-entry memory,
// a registered output stage and occupancy tracking. Define PROFILE_CNT_EN to build the profiling counters.
module stream_shell_sync #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_ADDR_BITS = 7,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_WIDTH-1:0]    din,
   input  logic                     val_in,
   output logic                     ready_upward,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     val_out,
   input  logic                     ready_downward,
   input  logic                     reset_ap_start,
   input  logic                     state,
   output logic                     full,
   output logic                     empty,
   output logic [NUM_ADDR_BITS+1:0] occupancy,
   output logic [NUM_ADDR_BITS+1:0] max_occupancy,
   output logic [CNT_WIDTH-1:0]     full_cnt,
   output logic [CNT_WIDTH-1:0]     empty_cnt,
   output logic [CNT_WIDTH-1:0]     read_cnt
);
   localparam int DEPTH = 2 ** NUM_ADDR_BITS;
   localparam int CW    = NUM_ADDR_BITS + 1;
   localparam int OW    = NUM_ADDR_BITS + 2;

   logic [DATA_WIDTH-1:0]    mem [DEPTH];
   logic [NUM_ADDR_BITS-1:0] wr_ptr;
   logic [NUM_ADDR_BITS-1:0] rd_ptr;
   logic [CW-1:0]            count;
   logic                     wr_en;
   logic                     load;
   logic                     pop;

   // Handshake: a word crosses an interface on the rising edge where its valid and ready are both
   // high; a raised valid holds, with stable data, until that edge. ready_upward comes only from count.
   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign ready_upward = ~full;
   assign wr_en        = val_in & ~full;
   assign load         = ~empty & (~val_out | ready_downward);
   assign pop          = val_out & ready_downward;
   assign occupancy    = {1'b0, count} + OW'(val_out);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + NUM_ADDR_BITS'(1);
         if (load)  rd_ptr <= rd_ptr + NUM_ADDR_BITS'(1);
         case ({wr_en, load})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // A pop without a load can only happen when the memory is empty, so the stage drains.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout    <= '0;
         val_out <= 1'b0;
      end else if (load) begin
         dout    <= mem[rd_ptr];
         val_out <= 1'b1;
      end else if (pop) begin
         val_out <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          max_occupancy <= '0;
      else if (reset_ap_start)            max_occupancy <= '0;
      else if (occupancy > max_occupancy) max_occupancy <= occupancy;
   end

`ifdef PROFILE_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_cnt  <= '0;
         empty_cnt <= '0;
         read_cnt  <= '0;
      end else if (reset_ap_start) begin
         full_cnt  <= '0;
         empty_cnt <= '0;
         read_cnt  <= '0;
      end else if (!state) begin
         if (full && full_cnt != '1)                empty_cnt <= empty_cnt;
         if (full && full_cnt != '1)                full_cnt  <= full_cnt + CNT_WIDTH'(1);
         if (empty && !val_out && empty_cnt != '1) empty_cnt <= empty_cnt + CNT_WIDTH'(1);
         if (pop && read_cnt != '1)                 read_cnt  <= read_cnt + CNT_WIDTH'(1);
      end
   end
`else
   logic unused_state;
   assign unused_state = state;
   assign full_cnt     = '0;
   assign empty_cnt    = '0;
   assign read_cnt     = '0;
`endif

endmodule

// File: tb/tb_stream_shell_sync.sv
// tb_stream_shell_sync: scoreboard bench for stream_shell_sync; a small instance (DEPTH=4, 4-bit
// counters) covers fill/drain, profiling and reset, a default-sized one covers long streaming.
module tb_stream_shell_sync;
`ifdef PROFILE_CNT_EN
   localparam bit PROF = 1'b1;
`else
   localparam bit PROF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  s_din, s_dout;
   logic        s_val_in, s_ready_up, s_val_out, s_ready_down, s_rap, s_state, s_full, s_empty;
   logic [3:0]  s_occ, s_max, s_full_cnt, s_empty_cnt, s_read_cnt;
   logic [7:0]  s_exp_q[$];

   logic [31:0] b_din, b_dout;
   logic        b_val_in, b_ready_up, b_val_out, b_ready_down, b_rap, b_state, b_full, b_empty;
   logic [8:0]  b_occ, b_max;
   logic [31:0] b_full_cnt, b_empty_cnt, b_read_cnt;
   logic [31:0] b_exp_q[$];

   stream_shell_sync #(.DATA_WIDTH(8), .NUM_ADDR_BITS(2), .CNT_WIDTH(4)) dut_small (
      .clk(clk), .reset(rst), .din(s_din), .val_in(s_val_in), .ready_upward(s_ready_up),
      .dout(s_dout), .val_out(s_val_out), .ready_downward(s_ready_down),
      .reset_ap_start(s_rap), .state(s_state), .full(s_full), .empty(s_empty),
      .occupancy(s_occ), .max_occupancy(s_max), .full_cnt(s_full_cnt),
      .empty_cnt(s_empty_cnt), .read_cnt(s_read_cnt)
   );

   stream_shell_sync #(.DATA_WIDTH(32), .NUM_ADDR_BITS(7), .CNT_WIDTH(32)) dut_big (
      .clk(clk), .reset(rst), .din(b_din), .val_in(b_val_in), .ready_upward(b_ready_up),
      .dout(b_dout), .val_out(b_val_out), .ready_downward(b_ready_down),
      .reset_ap_start(b_rap), .state(b_state), .full(b_full), .empty(b_empty),
      .occupancy(b_occ), .max_occupancy(b_max), .full_cnt(b_full_cnt),
      .empty_cnt(b_empty_cnt), .read_cnt(b_read_cnt)
   );

   // Scoreboard push: a word is expected whenever an upstream handshake is set up for the next edge.
   always @(negedge clk) begin
      if (!rst && s_val_in && s_ready_up) s_exp_q.push_back(s_din);
      if (!rst && b_val_in && b_ready_up) b_exp_q.push_back(b_din);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst = 1'b1;
      s_din = '0; s_val_in = 1'b0; s_ready_down = 1'b0; s_rap = 1'b0; s_state = 1'b0;
      b_din = '0; b_val_in = 1'b0; b_ready_down = 1'b0; b_rap = 1'b0; b_state = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (s_val_out !== 1'b0) begin errors++; $display("FAIL reset_val_out: got %b want 0", s_val_out); end
      checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", s_dout); end
      checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", s_full); end
      checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", s_empty); end
      checks++; if (s_ready_up !== 1'b1) begin errors++; $display("FAIL reset_ready_up: got %b want 1", s_ready_up); end
      checks++; if (s_occ !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", s_occ); end
      checks++; if (s_max !== 4'd0) begin errors++; $display("FAIL reset_max: got %0d want 0", s_max); end
      checks++; if ({s_full_cnt, s_empty_cnt, s_read_cnt} !== 12'h000) begin
         errors++; $display("FAIL reset_cnts: got %h want 000", {s_full_cnt, s_empty_cnt, s_read_cnt}); end
      checks++; if ({b_val_out, b_empty, b_full} !== 3'b010) begin
         errors++; $display("FAIL reset_big_flags: got %b want 010", {b_val_out, b_empty, b_full}); end
      checks++; if ({b_full_cnt, b_empty_cnt} !== 64'd0) begin
         errors++; $display("FAIL reset_big_cnts: got %h want 0", {b_full_cnt, b_empty_cnt}); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_latency();
      logic [7:0] exp;
      s_ready_down = 1'b1; s_din = 8'hA5; s_val_in = 1'b1;
      @(posedge clk); #1;
      s_val_in = 1'b0; s_din = 8'h00;
      checks++; if (s_occ !== 4'd1) begin errors++; $display("FAIL lat_occ_c1: got %0d want 1", s_occ); end
      checks++; if (s_val_out !== 1'b0) begin errors++; $display("FAIL lat_val_c1: got %b want 0", s_val_out); end
      @(posedge clk); #1;
      checks++; if (s_val_out !== 1'b1) begin errors++; $display("FAIL lat_val_c2: got %b want 1", s_val_out); end
      checks++; if (s_occ !== 4'd1) begin errors++; $display("FAIL lat_occ_c2: got %0d want 1", s_occ); end
      if (s_val_out && s_ready_down && s_exp_q.size() > 0) begin
         exp = s_exp_q.pop_front();
         checks++; if (s_dout !== exp) begin errors++; $display("FAIL lat_dout: got %h want %h", s_dout, exp); end
      end
      @(posedge clk); #1;
      checks++; if (s_val_out !== 1'b0) begin errors++; $display("FAIL lat_val_c3: got %b want 0", s_val_out); end
      checks++; if (s_occ !== 4'd0) begin errors++; $display("FAIL lat_occ_c3: got %0d want 0", s_occ); end
   endtask

   task automatic test_fill_drain();
      logic [7:0] exp;
      int n;
      s_ready_down = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         s_val_in = 1'b1; s_din = 8'(i);
         @(posedge clk); #1;
         if (i == 5) begin
            checks++; if (s_ready_up !== 1'b0) begin errors++; $display("FAIL fill_ready_up: got %b want 0", s_ready_up); end
            checks++; if (s_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", s_full); end
         end
      end
      s_val_in = 1'b0;
      checks++; if (s_occ !== 4'd5) begin errors++; $display("FAIL fill_occ: got %0d want 5", s_occ); end
      checks++; if (s_max !== 4'd5) begin errors++; $display("FAIL fill_max: got %0d want 5", s_max); end
      s_ready_down = 1'b1;
      #1;
      checks++; if (s_ready_up !== 1'b0) begin errors++; $display("FAIL fill_ready_comb: got %b want 0", s_ready_up); end
      n = 0;
      for (int c = 0; c < 20 && n < 5; c++) begin
         if (s_val_out && s_exp_q.size() > 0) begin
            exp = s_exp_q.pop_front();
            n++;
            checks++; if (s_dout !== exp) begin errors++; $display("FAIL drain_dout: got %h want %h", s_dout, exp); end
         end
         @(posedge clk); #1;
      end
      checks++; if (n !== 5) begin errors++; $display("FAIL drain_count: got %0d want 5", n); end
      checks++; if ({s_val_out, s_empty} !== 2'b01) begin
         errors++; $display("FAIL drain_idle: got %b want 01", {s_val_out, s_empty}); end
   endtask

   task automatic test_profile();
      logic [7:0] exp;
      int n;
      s_state = 1'b1; s_rap = 1'b1;
      @(posedge clk); #1;
      s_rap = 1'b0; s_ready_down = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_val_in = 1'b1; s_din = 8'h10 + 8'(i);
         @(posedge clk); #1;
      end
      s_val_in = 1'b0;
      checks++; if (s_full !== 1'b1) begin errors++; $display("FAIL prof_full: got %b want 1", s_full); end
      s_state = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      s_state = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      checks++; if (s_full_cnt !== (PROF ? 4'd10 : 4'd0)) begin
         errors++; $display("FAIL prof_full_cnt: got %0d want %0d", s_full_cnt, PROF ? 10 : 0); end
      checks++; if (s_empty_cnt !== 4'd0) begin errors++; $display("FAIL prof_empty_cnt0: got %0d want 0", s_empty_cnt); end
      checks++; if (s_read_cnt !== 4'd0) begin errors++; $display("FAIL prof_read_cnt0: got %0d want 0", s_read_cnt); end
      s_state = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      s_state = 1'b1;
      checks++; if (s_full_cnt !== (PROF ? 4'd15 : 4'd0)) begin
         errors++; $display("FAIL prof_saturate: got %0d want %0d", s_full_cnt, PROF ? 15 : 0); end
      s_state = 1'b0; s_rap = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      checks++; if (s_full_cnt !== 4'd0) begin errors++; $display("FAIL prof_clr_cnt: got %0d want 0", s_full_cnt); end
      checks++; if (s_max !== 4'd0) begin errors++; $display("FAIL prof_clr_max: got %0d want 0", s_max); end
      checks++; if (s_occ !== 4'd5) begin errors++; $display("FAIL prof_clr_occ: got %0d want 5", s_occ); end
      checks++; if ({s_val_out, s_dout} !== 9'h110) begin
         errors++; $display("FAIL prof_clr_data: got %h want 110", {s_val_out, s_dout}); end
      s_rap = 1'b0; s_ready_down = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && n < 5; c++) begin
         if (s_val_out && s_exp_q.size() > 0) begin
            exp = s_exp_q.pop_front();
            n++;
            checks++; if (s_dout !== exp) begin errors++; $display("FAIL prof_dout: got %h want %h", s_dout, exp); end
         end
         @(posedge clk); #1;
      end
      s_state = 1'b1;
      checks++; if (n !== 5) begin errors++; $display("FAIL prof_drain_count: got %0d want 5", n); end
      checks++; if (s_read_cnt !== (PROF ? 4'd5 : 4'd0)) begin
         errors++; $display("FAIL prof_read_cnt: got %0d want %0d", s_read_cnt, PROF ? 5 : 0); end
      checks++; if (s_empty_cnt !== 4'd0) begin errors++; $display("FAIL prof_empty_cnt1: got %0d want 0", s_empty_cnt); end
      s_state = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      s_state = 1'b1;
      checks++; if (s_empty_cnt !== (PROF ? 4'd3 : 4'd0)) begin
         errors++; $display("FAIL prof_empty_cnt2: got %0d want %0d", s_empty_cnt, PROF ? 3 : 0); end
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      int n, first, last, stalls;
      n = 0; first = -1; last = -1; stalls = 0;
      b_ready_down = 1'b1;
      for (int c = 0; c < 400 && n < 300; c++) begin
         if (c < 300) begin b_val_in = 1'b1; b_din = $urandom; end
         else b_val_in = 1'b0;
         if (!b_ready_up || b_full) stalls++;
         if (b_val_out && b_exp_q.size() > 0) begin
            if (first < 0) first = c;
            last = c;
            exp = b_exp_q.pop_front();
            n++;
            checks++; if (b_dout !== exp) begin errors++; $display("FAIL stream_dout: word %0d got %h want %h", n, b_dout, exp); end
         end
         @(posedge clk); #1;
      end
      b_val_in = 1'b0;
      checks++; if (n !== 300) begin errors++; $display("FAIL stream_count: got %0d want 300", n); end
      checks++; if (first !== 2) begin errors++; $display("FAIL stream_first: got %0d want 2", first); end
      checks++; if (last !== 301) begin errors++; $display("FAIL stream_last: got %0d want 301", last); end
      checks++; if (stalls !== 0) begin errors++; $display("FAIL stream_stalls: got %0d want 0", stalls); end
      checks++; if (b_max !== 9'd2) begin errors++; $display("FAIL stream_max: got %0d want 2", b_max); end
      checks++; if (b_occ !== 9'd0) begin errors++; $display("FAIL stream_occ: got %0d want 0", b_occ); end
      checks++; if (b_full_cnt !== 32'd0) begin errors++; $display("FAIL stream_full_cnt: got %0d want 0", b_full_cnt); end
      checks++; if (b_read_cnt !== (PROF ? 32'd300 : 32'd0)) begin
         errors++; $display("FAIL stream_read_cnt: got %0d want %0d", b_read_cnt, PROF ? 300 : 0); end
   endtask

   task automatic test_reset_midburst();
      s_ready_down = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_val_in = 1'b1; s_din = 8'h30 + 8'(i);
         @(posedge clk); #1;
      end
      s_val_in = 1'b0;
      checks++; if ({s_val_out, s_occ} !== 5'h13) begin
         errors++; $display("FAIL mid_pre: got %h want 13", {s_val_out, s_occ}); end
      #2 rst = 1'b1;
      #1;
      checks++; if (s_val_out !== 1'b0) begin errors++; $display("FAIL mid_val_out: got %b want 0", s_val_out); end
      checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b want 1", s_empty); end
      checks++; if (s_occ !== 4'd0) begin errors++; $display("FAIL mid_occ: got %0d want 0", s_occ); end
      checks++; if (s_max !== 4'd0) begin errors++; $display("FAIL mid_max: got %0d want 0", s_max); end
      s_exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_fill_drain();
      test_profile();
      test_stream();
      test_reset_midburst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
